// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, branch redirect, local imem.
// Stops permanently on HALT_WORD or an unfetchable PC until reset.
module instr_fetch #(
  parameter int                   WORD       = 64,
  parameter int                   INSTR_LEN  = 32,
  parameter int                   IMEM_DEPTH = 256,
  parameter logic [WORD-1:0]      RESET_PC   = '0,
  parameter logic [INSTR_LEN-1:0] HALT_WORD  = 32'hD4400000,
  localparam int                  AW = $clog2(IMEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 uncondbranch,
  input  logic                 branch,
  input  logic                 zero,
  input  logic [WORD-1:0]      branch_pc,
  input  logic [WORD-1:0]      branch_offset,
  input  logic                 imem_we,
  input  logic [AW-1:0]        imem_waddr,
  input  logic [INSTR_LEN-1:0] imem_wdata,
  output logic [INSTR_LEN-1:0] instruction,
  output logic [WORD-1:0]      pc_out,
  output logic                 valid_out,
  output logic                 halted,
  output logic                 fault
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t               state;
  logic [WORD-1:0]      pc;
  logic [WORD-1:0]      target;
  logic                 taken;
  logic                 bad_pc;
  logic [INSTR_LEN-1:0] rd_word;
  logic [INSTR_LEN-1:0] imem [IMEM_DEPTH];

  assign taken   = uncondbranch | (branch & zero);
  assign target  = branch_pc + (branch_offset << 2);
  assign bad_pc  = (pc[1:0] != 2'b00) ||
                   ((pc >> 2) >= WORD'(IMEM_DEPTH));
  assign rd_word = imem[pc[AW+1:2]];

  // Program store survives reset; reads see pre-write contents.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instruction <= '0;
      pc_out      <= '0;
      valid_out   <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
          // A redirect overrides stall: the held slot is wrong-path.
          if (taken) begin
            pc        <= target;
            valid_out <= 1'b0;
          end else if (!stall) begin
            if (bad_pc) begin
              valid_out <= 1'b0;
              fault     <= 1'b1;
              state     <= HALT;
            end else if (rd_word == HALT_WORD) begin
              instruction <= rd_word;
              pc_out      <= pc;
              valid_out   <= 1'b0;
              halted      <= 1'b1;
              state       <= HALT;
            end else begin
              instruction <= rd_word;
              pc_out      <= pc;
              valid_out   <= 1'b1;
              pc          <= pc + WORD'(4);
            end
          end
        end
        HALT: valid_out <= 1'b0;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, corner sequences,
// then random stimulus against a behavioural fetch model.
module tb_instr_fetch;

  localparam int          D  = 256;
  localparam logic [31:0] HW = 32'hD4400000;

  logic        clk;
  logic        rst_n;
  logic        stall, uncondbranch, branch, zero;
  logic [63:0] branch_pc, branch_offset;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] instruction;
  logic [63:0] pc_out;
  logic        valid_out, halted, fault;

  instr_fetch #(
    .WORD(64), .INSTR_LEN(32), .IMEM_DEPTH(D),
    .RESET_PC(64'h0), .HALT_WORD(HW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .uncondbranch(uncondbranch), .branch(branch), .zero(zero),
    .branch_pc(branch_pc), .branch_offset(branch_offset),
    .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .instruction(instruction),
    .pc_out(pc_out), .valid_out(valid_out),
    .halted(halted), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model
  int          m_mode;  // 0 boot, 1 running, 2 stopped
  logic [63:0] m_pc, m_pcout;
  logic [31:0] m_instr;
  logic        m_valid, m_halted, m_fault;
  logic [31:0] m_mem [D];

  function automatic logic [31:0] word(input int i);
    return 32'h0100_0000 | 32'(i);
  endfunction

  task automatic check(input string nm, input logic v,
                       input logic [63:0] p, input logic [31:0] ins,
                       input logic h, input logic f);
    vectors++;
    if (valid_out !== v || pc_out !== p || instruction !== ins ||
        halted !== h || fault !== f) begin
      miscompares++;
      $display("FAIL %s: got v=%0b pc=%h ins=%h h=%0b f=%0b want v=%0b pc=%h ins=%h h=%0b f=%0b",
               nm, valid_out, pc_out, instruction, halted, fault,
               v, p, ins, h, f);
    end
  endtask

  task automatic check_rst(input string nm);
    check(nm, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_model(input string nm);
    check(nm, m_valid, m_pcout, m_instr, m_halted, m_fault);
  endtask

  task automatic model_step(input logic s, u, b, z,
                            input logic [63:0] bp, bo,
                            input logic we, input logic [7:0] wa,
                            input logic [31:0] wd);
    logic [31:0] w;
    if (!rst_n) begin
      m_mode = 0; m_pc = 64'h0; m_pcout = 64'h0; m_instr = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (u || (b && z)) begin
        m_pc = bp + bo * 4;
        m_valid = 1'b0;
      end else if (!s) begin
        if (m_pc % 4 != 0 || m_pc / 4 >= D) begin
          m_valid = 1'b0; m_fault = 1'b1; m_mode = 2;
        end else begin
          w = m_mem[int'(m_pc / 4)];
          m_instr = w;
          m_pcout = m_pc;
          if (w == HW) begin
            m_valid = 1'b0; m_halted = 1'b1; m_mode = 2;
          end else begin
            m_valid = 1'b1; m_pc = m_pc + 4;
          end
        end
      end
    end
    if (we) m_mem[wa] = wd;
  endtask

  task automatic tick(input logic s, u, b, z,
                      input logic [63:0] bp, bo,
                      input logic we, input logic [7:0] wa,
                      input logic [31:0] wd);
    stall = s; uncondbranch = u; branch = b; zero = z;
    branch_pc = bp; branch_offset = bo;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    @(posedge clk);
    model_step(s, u, b, z, bp, bo, we, wa, wd);
    #1;
  endtask

  task automatic nop();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, a, d);
  endtask

  typedef struct {
    logic        s, u, b, z;
    logic [63:0] bp, bo;
    logic        v;
    logic [63:0] p;
    logic [31:0] ins;
    logic        h, f;
  } vec_t;

  localparam logic [63:0] NEG2 = 64'hFFFF_FFFF_FFFF_FFFE;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,64'h0,  64'h0,1'b0,64'h0, 32'h0,   1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,64'h0,  64'h0,1'b1,64'h0, word(0), 1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,64'h0,  64'h0,1'b1,64'h4, word(1), 1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,64'h0,  64'h0,1'b1,64'h8, word(2), 1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b1,1'b1,64'h8,  NEG2, 1'b0,64'h8, word(2), 1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,64'h0,  64'h0,1'b1,64'h0, word(0), 1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b0,1'b0,64'h30, 64'h4,1'b0,64'h0, word(0), 1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,64'h0,  64'h0,1'b0,64'h0, word(0), 1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,64'h0,  64'h0,1'b1,64'h40,word(16),1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,64'h0,  64'h0,1'b1,64'h40,word(16),1'b0,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b0,64'h0,  64'h0,1'b1,64'h44,word(17),1'b0,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b1,64'h0,  64'h0,1'b1,64'h48,word(18),1'b0,1'b0};
    tbl[12] = '{1'b0,1'b1,1'b0,1'b0,64'h3FC,64'h1,1'b0,64'h48,word(18),1'b0,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b0,64'h0,  64'h0,1'b0,64'h48,word(18),1'b0,1'b1};
    tbl[14] = '{1'b0,1'b1,1'b0,1'b0,64'h0,  64'h0,1'b0,64'h48,word(18),1'b0,1'b1};

    rst_n = 1'b1;
    stall = 1'b0; uncondbranch = 1'b0; branch = 1'b0; zero = 1'b0;
    branch_pc = 64'h0; branch_offset = 64'h0;
    imem_we = 1'b0; imem_waddr = 8'h0; imem_wdata = 32'h0;
    #2 rst_n = 1'b0;
    #1 check_rst("async_reset");

    for (int i = 0; i < D; i++) load(8'(i), word(i));
    check_rst("reset_hold");

    // table: sequential fetch, branches, stall+taken, range fault
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].s, tbl[i].u, tbl[i].b, tbl[i].z, tbl[i].bp,
           tbl[i].bo, 1'b0, 8'h0, 32'h0);
      check($sformatf("tbl%0d", i), tbl[i].v, tbl[i].p, tbl[i].ins,
            tbl[i].h, tbl[i].f);
    end

    // misaligned redirect faults; reset pulse recovers
    rst_n = 1'b0;
    #1 check_rst("reset_from_fault");
    rst_n = 1'b1;
    nop(); check_rst("boot_again");
    nop(); check("fetch0", 1'b1, 64'h0, word(0), 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 64'h6, 64'h0, 1'b0, 8'h0, 32'h0);
    check("to_misaligned", 1'b0, 64'h0, word(0), 1'b0, 1'b0);
    nop(); check("misalign_fault", 1'b0, 64'h0, word(0), 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 64'h0, 64'h0, 1'b0, 8'h0, 32'h0);
    check("fault_sticky", 1'b0, 64'h0, word(0), 1'b0, 1'b1);
    rst_n = 1'b0;
    #1 check_rst("fault_cleared");
    rst_n = 1'b1;
    nop(); check_rst("boot_after_fault");
    nop(); check("refetch0", 1'b1, 64'h0, word(0), 1'b0, 1'b0);

    // halt word at 3; write to the word being fetched reads old
    rst_n = 1'b0;
    load(8'd3, HW);
    rst_n = 1'b1;
    nop(); check_rst("halt_boot");
    nop(); check("h_pc0", 1'b1, 64'h0, word(0), 1'b0, 1'b0);
    nop(); check("h_pc4", 1'b1, 64'h4, word(1), 1'b0, 1'b0);
    load(8'd2, 32'hDEAD_BEEF);
    check("wr_old_word", 1'b1, 64'h8, word(2), 1'b0, 1'b0);
    nop(); check("halt_hit", 1'b0, 64'hC, HW, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 8'h0, 32'h0);
    check("halt_ign_unc", 1'b0, 64'hC, HW, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 64'h0, 64'h0, 1'b0, 8'h0, 32'h0);
    check("halt_ign_br", 1'b0, 64'hC, HW, 1'b1, 1'b0);
    rst_n = 1'b0;
    nop(); check_rst("halt_reset");
    nop(); check_model("model_sync");
    rst_n = 1'b1;
    nop(); check_model("new_word_boot");
    nop(); check("new_word0", 1'b1, 64'h0, word(0), 1'b0, 1'b0);
    nop(); check("new_word1", 1'b1, 64'h4, word(1), 1'b0, 1'b0);
    nop(); check("new_word2", 1'b1, 64'h8, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // random stimulus against the model
    rst_n = 1'b0;
    load(8'd3, word(3));
    check_model("rand_start");
    for (int n = 0; n < 4000; n++) begin
      logic        s, u, b, z, we;
      logic [63:0] bp, bo;
      logic [7:0]  wa;
      logic [31:0] wd;
      int          r, o;
      rst_n = ($urandom_range(0, 39) != 0);
      s = ($urandom_range(0, 3) == 0);
      u = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 4) == 0);
      z = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 49));
      if (r == 0)      bp = {32'h0, 22'h0, 10'($urandom)};
      else if (r == 1) bp = 64'h3F0;
      else             bp = 64'($urandom_range(0, 63)) * 4;
      o = int'($urandom_range(0, 16)) - 8;
      bo = {{32{o[31]}}, o};
      we = ($urandom_range(0, 7) == 0);
      wa = 8'($urandom_range(0, 63));
      wd = ($urandom_range(0, 30) == 0) ? HW : $urandom;
      tick(s, u, b, z, bp, bo, we, wa, wd);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
